// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, operand widths and default cycle counts.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mdu_pkg;

  localparam int MDU_OP_W  = 3;
  localparam int MDU_CNT_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_NONE  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd6;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Architectural HI/LO pair, HI in the upper word.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_hilo_t;

  function automatic logic mdu_is_mul(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// MDU datapath: 64-bit product or quotient/remainder of the latched operands.
// Latency: purely combinational, result valid in the same cycle as a/b/op.
// Backpressure: none; the owning state machine decides when to sample it.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic [31:0]         res_hi,
  output logic [31:0]         res_lo,
  output logic                div_by_zero
);

  logic        signed_op;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] quo;
  logic [31:0] rem;
  mdu_hilo_t   res;

  // Signed ops share the unsigned multiplier/divider: multiply on sign-extended
  // operands (low 64 bits are exact), divide on magnitudes then fix signs.
  // The most-negative dividend has magnitude 0x80000000, which makes the
  // 0x80000000 / -1 overflow case fall out as lo=0x80000000, hi=0 naturally.
  always_comb begin
    signed_op   = (op == MDU_MULT) || (op == MDU_DIV);
    ext_a       = signed_op ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b       = signed_op ? {{32{b[31]}}, b} : {32'd0, b};
    prod        = ext_a * ext_b;
    neg_a       = signed_op & a[31];
    neg_b       = signed_op & b[31];
    mag_a       = neg_a ? (~a + 32'd1) : a;
    mag_b       = neg_b ? (~b + 32'd1) : b;
    // Keep the divider defined on b==0; the owner discards that result.
    safe_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo         = mag_a / safe_b;
    rem         = mag_a % safe_b;
    div_by_zero = mdu_is_div(op) && (b == 32'd0);
    res         = '0;
    if (mdu_is_mul(op)) begin
      res = prod;
    end else if (mdu_is_div(op)) begin
      res.lo = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
      res.hi = neg_a ? (~rem + 32'd1) : rem;
    end
    res_hi = res.hi;
    res_lo = res.lo;
  end

endmodule

// File: rtl/mdu.sv
// MIPS multiply/divide unit holding HI/LO; MTHI/MTLO write in one edge.
// Latency: MULT* commit MULT_CYCLES edges after accept, DIV* after DIV_CYCLES.
// Backpressure: busy high while an op is in flight; start is dropped when busy.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,  // 1..15
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF    // 1..15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic                busy,
  output logic [31:0]         hi,
  output logic [31:0]         lo
);

  localparam logic [MDU_CNT_W-1:0] MULT_N = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_N  = MDU_CNT_W'(DIV_CYCLES);

  logic [MDU_OP_W-1:0]  op_q;
  logic [31:0]          a_q;
  logic [31:0]          b_q;
  logic [MDU_CNT_W-1:0] counter;
  logic [31:0]          res_hi;
  logic [31:0]          res_lo;
  logic                 div_by_zero;
  logic                 accept;
  logic                 commit;

  assign busy   = (counter != '0);
  assign accept = start && !busy;
  assign commit = (counter == MDU_CNT_W'(1));

  mdu_calc u_calc (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  // Latch operands on accept and count down the busy window; the final
  // decrement from 1 lands on 0 on the same edge HI/LO commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      counter <= '0;
    end else if (busy) begin
      counter <= counter - MDU_CNT_W'(1);
    end else if (accept && (mdu_is_mul(op) || mdu_is_div(op))) begin
      op_q    <= op;
      a_q     <= a;
      b_q     <= b;
      counter <= mdu_is_mul(op) ? MULT_N : DIV_N;
    end
  end

  // HI/LO update: commit of an arithmetic result (skipped on divide by zero)
  // or a direct move from rs when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (!div_by_zero) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (accept && (op == MDU_MTHI)) begin
      hi <= a;
    end else if (accept && (op == MDU_MTLO)) begin
      lo <= a;
    end
  end

endmodule
